gmii_rx_frame_checker: RTL and testbench
========================================

GMII_RX_FRAME_CHECKER -- requirements
Module: gmii_rx_frame_checker

Interface
REQ-001 Parameter: MIN_FRAME, default 64, minimum legal frame length in bytes, counted from the first byte after the SFD and including the FCS.
REQ-002 gmii_rx_clk  input  1  sole clock; 125/25/2.5 MHz receive clock.
REQ-003 gmii_rx_reset  input  1  asynchronous, active-high reset.
REQ-004 speed_10_100  input  1  0 = 1 Gbps byte mode; 1 = 10/100 nibble mode, where only gmii_rxd[3:0] is valid.
REQ-005 gmii_rxd  input  8  registered receive data.
REQ-006 gmii_rx_dv  input  1  receive data valid.
REQ-007 gmii_rx_er  input  1  receive error.
REQ-008 rx_data  output  8  payload byte, FCS stripped.
REQ-009 rx_valid  output  1  rx_data is valid this cycle.
REQ-010 rx_sof  output  1  marks the first payload byte; qualified by rx_valid.
REQ-011 rx_eof  output  1  marks the last payload byte; qualified by rx_valid.
REQ-012 rx_err  output  1  frame bad; meaningful only with rx_eof.
REQ-013 rx_frame_cnt  output  16  count of good frames, saturating.
REQ-014 rx_err_cnt  output  16  count of bad or dropped frames, saturating.

Function
REQ-015 The state machine SHALL have four states: IDLE, PREAMBLE, DATA and DROP.
REQ-016 IDLE SHALL go to PREAMBLE on gmii_rx_dv=1.
REQ-017 In byte mode, PREAMBLE SHALL behave as follows:
- 0x55: stay in PREAMBLE.
- 0xD5: go to DATA.
- any other value: go to DROP.
REQ-018 In nibble mode, PREAMBLE SHALL behave as follows:
- nibble 0x5: stay in PREAMBLE.
- nibble 0xD: go to DATA, with the nibble phase cleared.
- any other value: go to DROP.
REQ-019 gmii_rx_dv=0 in PREAMBLE SHALL return the block to IDLE with no output and no counter change.
REQ-020 DROP SHALL wait for gmii_rx_dv=0, then go to IDLE and increment rx_err_cnt once.
REQ-021 In nibble mode, DATA SHALL assemble a byte from the first nibble (bits [3:0]) and the second nibble (bits [7:4]); a byte is accepted on every second-nibble cycle.
REQ-022 In byte mode, DATA SHALL accept one byte per cycle.
REQ-023 Every accepted byte SHALL feed the CRC-32 engine and a 4-byte FCS delay line.
REQ-024 CRC-32 parameters: IEEE 802.3 reflected form, polynomial 0x04C11DB7, initial value 0xFFFFFFFF, reset at SFD; computed over all bytes including the FCS. The frame is good when the register equals residue 0xC704DD7B.
REQ-025 A byte leaving the FCS delay line SHALL enter a 1-byte hold register.
REQ-026 The previously held byte SHALL be emitted with rx_valid=1 and rx_eof=0 on the cycle after its successor enters the hold register.
REQ-027 rx_sof SHALL be 1 on the first emitted byte of a frame.
REQ-028 End of frame in DATA (gmii_rx_dv falling) SHALL, on the next cycle, emit the held byte with rx_eof=1 and rx_err set as described in REQ-029.
REQ-029 rx_err SHALL be 1 if any of the following holds:
- CRC residue mismatch;
- gmii_rx_er seen at any point in DATA;
- byte count below MIN_FRAME;
- nibble mode ends with an odd nibble count.
REQ-030 At the same time as the eof byte, rx_frame_cnt SHALL increment if rx_err=0, otherwise rx_err_cnt SHALL increment.
REQ-031 A frame with 4 or fewer post-SFD bytes SHALL emit no output and SHALL increment rx_err_cnt.
REQ-032 A frame of exactly 5 bytes SHALL emit one byte with rx_sof=rx_eof=1.
REQ-033 Both counters SHALL hold at 0xFFFF.
REQ-034 Output latency in byte mode SHALL be: byte k emitted 6 cycles after it is presented on gmii_rxd.
REQ-035 speed_10_100 SHALL be sampled only in IDLE; changes mid-frame SHALL be ignored.
REQ-036 gmii_rx_dv re-asserting on the cycle the eof byte is emitted SHALL start a new PREAMBLE with no loss.
REQ-037 rx_valid SHALL never be asserted outside DATA or the eof cycle.

Reset
REQ-038 On gmii_rx_reset=1, asynchronously:
- state goes to IDLE;
- rx_data, rx_valid, rx_sof, rx_eof and rx_err go to 0;
- both counters go to 0;
- the CRC register goes to 0xFFFFFFFF;
- the delay line and nibble phase are cleared.
REQ-039 Reset asserted mid-frame SHALL abandon the frame with no eof and no counter update.
REQ-040 After release, the block SHALL ignore gmii_rx_dv until it has been seen low, so that no partial frame is captured.

Structure
REQ-041 The following constants SHALL live in the shared uimac_rx_defs package/include:
- preamble value 0x55;
- SFD value 0xD5;
- CRC polynomial;
- CRC residue 0xC704DD7B;
- state encodings.
REQ-042 A single sub-module, crc32_d8, SHALL hold the combinational CRC-32 update of 8 data bits; it is instantiated once.

Verification
REQ-043 The bench SHALL cover these directed scenarios:
- Gbps: 7×0x55, 0xD5, 60-byte payload 0x00..0x3B, correct FCS -> 60 rx_valid bytes 0x00..0x3B; sof on 0x00; eof on 0x3B; rx_err=0; rx_frame_cnt=1.
- Same frame with FCS last byte XOR 0x01 -> eof with rx_err=1; rx_err_cnt=1; rx_frame_cnt unchanged.
- Nibble mode, 25 MHz: same 64-byte frame sent as low/high nibbles -> identical output byte stream; rx_err=0.
- Gbps: preamble 0x55,0x55,0x5A -> DROP; no rx_valid; rx_err_cnt=1 after dv falls.
- gmii_rx_er pulsed on payload byte 10 of a good-CRC frame -> eof with rx_err=1.
- Reset asserted on payload byte 20, then released mid-dv -> no output until the next full frame; both counters 0; the next good frame is counted normally.

Source files
------------

// File: rtl/uimac_rx_defs.sv
// Shared receive-path constants: preamble/SFD values, CRC-32 parameters and
// the frame checker state encoding.
package uimac_rx_defs;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 update over one byte, reflected (LSB-first) form.
module crc32_d8
    import uimac_rx_defs::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    localparam logic [31:0] POLY_REFL = bitrev32(CRC_POLY);

    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++)
            crc_next = {1'b0, crc_next[31:1]} ^ ((crc_next[0] ^ data[i]) ? POLY_REFL : 32'h0);
    end

endmodule

// File: rtl/gmii_rx_frame_checker.sv
// GMII/MII receive frame checker: strips preamble and FCS, checks CRC, length,
// rx_er and nibble alignment, and counts good and bad frames.
module gmii_rx_frame_checker
    import uimac_rx_defs::*;
#(
    parameter int MIN_FRAME = 64
) (
    input  logic        gmii_rx_clk,
    input  logic        gmii_rx_reset,
    input  logic        speed_10_100,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_err,
    output logic [15:0] rx_frame_cnt,
    output logic [15:0] rx_err_cnt
);

    rx_state_e       state_q, state_d;
    logic            nib_mode, armed, phase, er_seen, sent;
    logic [3:0]      low_nib;
    logic [15:0]     byte_cnt;
    logic [3:0][7:0] fcs_dly;
    logic [7:0]      hold, byte_in;
    logic [31:0]     crc_q, crc_next;
    logic            sfd_hit, is_pre, is_sfd, accept, end_frame, drop_end;
    logic            frame_bad, good_inc, err_inc;

    crc32_d8 u_crc (.crc(crc_q), .data(byte_in), .crc_next(crc_next));

    assign is_pre = nib_mode ? (gmii_rxd[3:0] == PREAMBLE_BYTE[3:0]) : (gmii_rxd == PREAMBLE_BYTE);
    assign is_sfd = nib_mode ? (gmii_rxd[3:0] == SFD_BYTE[7:4]) : (gmii_rxd == SFD_BYTE);

    always_ff @(posedge gmii_rx_clk or posedge gmii_rx_reset)
        if (gmii_rx_reset) state_q <= ST_IDLE;
        else               state_q <= state_d;

    always_comb begin
        state_d = state_q;
        sfd_hit = 1'b0;
        case (state_q)
            ST_IDLE:     if (gmii_rx_dv && armed) state_d = ST_PREAMBLE;
            ST_PREAMBLE: begin
                if (!gmii_rx_dv) state_d = ST_IDLE;
                else if (is_pre) state_d = ST_PREAMBLE;
                else if (is_sfd) begin
                    state_d = ST_DATA;
                    sfd_hit = 1'b1;
                end
                else state_d = ST_DROP;
            end
            ST_DATA:     if (!gmii_rx_dv) state_d = ST_IDLE;
            ST_DROP:     if (!gmii_rx_dv) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // In nibble mode the low nibble arrives first and is held until its partner.
    assign byte_in   = nib_mode ? {gmii_rxd[3:0], low_nib} : gmii_rxd;
    assign accept    = (state_q == ST_DATA) && gmii_rx_dv && (!nib_mode || phase);
    assign end_frame = (state_q == ST_DATA) && !gmii_rx_dv;
    assign drop_end  = (state_q == ST_DROP) && !gmii_rx_dv;

    // The register is kept LSB-first; reversing it gives the textbook residue.
    assign frame_bad = (bitrev32(crc_q) != CRC_RESIDUE) || er_seen
                     || (byte_cnt < 16'(MIN_FRAME)) || phase;
    assign good_inc  = end_frame && (byte_cnt >= 16'd5) && !frame_bad;
    assign err_inc   = drop_end || (end_frame && !good_inc);

    always_ff @(posedge gmii_rx_clk or posedge gmii_rx_reset) begin
        if (gmii_rx_reset) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_sof       <= 1'b0;
            rx_eof       <= 1'b0;
            rx_err       <= 1'b0;
            rx_frame_cnt <= '0;
            rx_err_cnt   <= '0;
            crc_q        <= CRC_INIT;
            fcs_dly      <= '0;
            hold         <= '0;
            byte_cnt     <= '0;
            low_nib      <= '0;
            phase        <= 1'b0;
            er_seen      <= 1'b0;
            sent         <= 1'b0;
            nib_mode     <= 1'b0;
            armed        <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
            rx_err   <= 1'b0;
            // Coming out of reset mid-frame, wait for a quiet line first.
            armed    <= armed | ~gmii_rx_dv;
            if (state_q == ST_IDLE) nib_mode <= speed_10_100;
            if (sfd_hit) begin
                crc_q    <= CRC_INIT;
                byte_cnt <= '0;
                phase    <= 1'b0;
                er_seen  <= 1'b0;
                sent     <= 1'b0;
            end
            if (state_q == ST_DATA && gmii_rx_dv) begin
                if (gmii_rx_er) er_seen <= 1'b1;
                if (nib_mode) begin
                    phase   <= ~phase;
                    low_nib <= gmii_rxd[3:0];
                end
            end
            if (accept) begin
                crc_q   <= crc_next;
                fcs_dly <= {fcs_dly[2:0], byte_in};
                if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
                if (byte_cnt >= 16'd4) hold <= fcs_dly[3];
                if (byte_cnt >= 16'd5) begin
                    rx_valid <= 1'b1;
                    rx_data  <= hold;
                    rx_sof   <= ~sent;
                    sent     <= 1'b1;
                end
            end
            if (end_frame && byte_cnt >= 16'd5) begin
                rx_valid <= 1'b1;
                rx_eof   <= 1'b1;
                rx_data  <= hold;
                rx_sof   <= ~sent;
                rx_err   <= frame_bad;
            end
            if (good_inc && rx_frame_cnt != 16'hFFFF) rx_frame_cnt <= rx_frame_cnt + 16'd1;
            if (err_inc && rx_err_cnt != 16'hFFFF)    rx_err_cnt   <= rx_err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// Bench for gmii_rx_frame_checker: directed and random frames compared against
// a frame-level model (expected payload stream and counter totals).
module tb_gmii_rx_frame_checker;

    localparam int MIN_FRAME = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        speed = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic        dv = 1'b0;
    logic        er = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_err;
    logic [15:0] rx_frame_cnt, rx_err_cnt;

    gmii_rx_frame_checker #(.MIN_FRAME(MIN_FRAME)) dut (
        .gmii_rx_clk (clk),
        .gmii_rx_reset(rst),
        .speed_10_100(speed),
        .gmii_rxd    (rxd),
        .gmii_rx_dv  (dv),
        .gmii_rx_er  (er),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_sof      (rx_sof),
        .rx_eof      (rx_eof),
        .rx_err      (rx_err),
        .rx_frame_cnt(rx_frame_cnt),
        .rx_err_cnt  (rx_err_cnt)
    );

    always #4 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_first = 0;
    int exp_frm = 0;
    int exp_err = 0;
    logic [7:0]  frm[$];
    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];
    int          got_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rx_valid) begin
            got_q.push_back({rx_data, rx_sof, rx_eof, rx_eof & rx_err});
            got_cyc.push_back(cyc);
        end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Post-SFD bytes: payload followed by its FCS (optionally corrupted).
    task automatic make_frame(input int plen, input bit incr, input bit bad);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        frm.delete();
        for (int i = 0; i < plen; i++) frm.push_back(incr ? 8'(i) : 8'($urandom));
        for (int i = 0; i < plen; i++) c = crc_upd(c, frm[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
        if (bad) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
    endtask

    task automatic make_raw(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
    endtask

    // Expected output: everything but the last 4 bytes; frames under 5 bytes are silent.
    task automatic model(input bit er_hit, input bit odd, input bit pre_bad);
        int n;
        logic [31:0] c;
        bit fcs_ok, bad;
        n = frm.size();
        fcs_ok = 1'b0;
        if (!pre_bad && n >= 4) begin
            c = 32'hFFFFFFFF;
            for (int i = 0; i < n - 4; i++) c = crc_upd(c, frm[i]);
            c = ~c;
            fcs_ok = ({frm[n-1], frm[n-2], frm[n-3], frm[n-4]} == c);
        end
        bad = !fcs_ok || er_hit || odd || (n < MIN_FRAME);
        if (pre_bad || n < 5) exp_err++;
        else begin
            for (int i = 0; i <= n - 5; i++)
                exp_q.push_back({frm[i], i == 0, i == n - 5, (i == n - 5) && bad});
            if (bad) exp_err++;
            else     exp_frm++;
        end
    endtask

    task automatic send(input bit nib, input int npre, input bit pre_bad, input int er_idx,
                        input bit odd, input int rst_at, input int gap);
        logic [7:0] w[$];
        int fi;
        logic e;
        for (int i = 0; i < npre; i++) w.push_back((pre_bad && i == 2) ? 8'h5A : 8'h55);
        w.push_back(8'hD5);
        foreach (frm[i]) w.push_back(frm[i]);
        for (int i = 0; i < w.size(); i++) begin
            fi = i - npre - 1;
            e = (fi >= 0) && (fi == er_idx);
            if (i == rst_at) rst = 1'b1;
            if (i == rst_at + 3) begin
                chk("rst_hold", {rx_valid, rx_eof, rx_frame_cnt, rx_err_cnt}, 0);
                rst = 1'b0;
                got_q.delete();
                got_cyc.delete();
            end
            for (int h = 0; h < (nib ? 2 : 1); h++) begin
                tick();
                speed = (i == 0) ? nib : 1'($urandom);
                dv = 1'b1;
                er = e;
                if (!nib)        rxd = w[i];
                else if (h == 0) rxd = {4'($urandom), w[i][3:0]};
                else             rxd = {4'($urandom), w[i][7:4]};
                if (fi == 0 && h == 0) t_first = cyc;
            end
        end
        if (odd) begin
            tick();
            dv = 1'b1;
            er = 1'b0;
            rxd = 8'($urandom);
        end
        for (int g = 0; g < gap; g++) begin
            tick();
            dv = 1'b0;
            er = 1'b0;
            rxd = 8'($urandom);
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_beat"}, got_q[i], exp_q[i]);
        chk({tag, "_frame_cnt"}, rx_frame_cnt, exp_frm);
        chk({tag, "_err_cnt"}, rx_err_cnt, exp_err);
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        int plen, n, er_idx;
        bit nib, bad, pre_bad, odd, shortf;

        repeat (3) tick();
        chk("reset_out", {rx_data, rx_valid, rx_sof, rx_eof, rx_err}, 0);
        chk("reset_cnt", {rx_frame_cnt, rx_err_cnt}, 0);
        rst = 1'b0;
        repeat (3) tick();

        make_frame(60, 1, 0); model(0, 0, 0);
        send(0, 7, 0, -1, 0, -10, 12);
        chk("latency", (got_cyc.size() > 0) ? got_cyc[0] - t_first : -1, 6);
        compare("gbps_good");

        make_frame(60, 1, 1); model(0, 0, 0);
        send(0, 7, 0, -1, 0, -10, 12);
        compare("gbps_badfcs");

        make_frame(60, 1, 0); model(0, 0, 0);
        send(1, 7, 0, -1, 0, -10, 12);
        compare("nibble_good");

        make_frame(60, 1, 0); model(0, 0, 1);
        send(0, 7, 1, -1, 0, -10, 12);
        compare("bad_preamble");

        make_frame(60, 1, 0); model(1, 0, 0);
        send(0, 7, 0, 10, 0, -10, 12);
        compare("rx_er");

        make_frame(60, 1, 0); model(0, 1, 0);
        send(1, 7, 0, -1, 1, -10, 12);
        compare("odd_nibble");

        make_frame(0, 0, 0);  model(0, 0, 0); send(0, 7, 0, -1, 0, -10, 12); compare("len4");
        make_frame(1, 0, 0);  model(0, 0, 0); send(0, 7, 0, -1, 0, -10, 12); compare("len5");
        make_frame(59, 0, 0); model(0, 0, 0); send(0, 7, 0, -1, 0, -10, 12); compare("len63");
        make_frame(60, 0, 0); model(0, 0, 0); send(0, 7, 0, -1, 0, -10, 12); compare("len64");

        make_frame(62, 0, 0); model(0, 0, 0); send(0, 7, 0, -1, 0, -10, 1);
        make_frame(64, 0, 0); model(0, 0, 0); send(0, 7, 0, -1, 0, -10, 12);
        compare("back_to_back");

        make_frame(60, 1, 0);
        send(0, 7, 0, -1, 0, 28, 12);
        exp_frm = 0;
        exp_err = 0;
        compare("reset_midframe");
        make_frame(60, 1, 0); model(0, 0, 0);
        send(0, 7, 0, -1, 0, -10, 12);
        compare("after_reset");

        for (int t = 0; t < 30; t++) begin
            nib     = 1'($urandom);
            shortf  = ($urandom_range(0, 3) == 0);
            bad     = ($urandom_range(0, 3) == 0);
            pre_bad = ($urandom_range(0, 9) == 0);
            odd     = nib && ($urandom_range(0, 9) == 0);
            if (shortf) make_raw($urandom_range(0, 8));
            else begin
                plen = $urandom_range(55, 90);
                make_frame(plen, 0, bad);
            end
            n = frm.size();
            er_idx = (n > 0 && $urandom_range(0, 6) == 0) ? $urandom_range(0, n - 1) : -1;
            model(er_idx >= 0, odd, pre_bad);
            send(nib, pre_bad ? $urandom_range(3, 7) : $urandom_range(1, 7), pre_bad, er_idx,
                 odd, -10, ($urandom_range(0, 2) == 0) ? 1 : 12);
            if (t % 5 == 4) begin
                repeat (12) tick();
                compare("random");
            end
        end
        repeat (12) tick();
        compare("random_end");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
